// File: rtl/scan_pattern_engine.sv
// Tester-side scan engine: streams per-cycle stimulus into five scan chains,
// pulses capture between patterns and counts masked mismatches on the unload.
module scan_pattern_engine #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [4:0]       pat_data,
  input  logic [4:0]       pat_exp,
  input  logic [4:0]       pat_mask,
  output logic             scan_in0,
  output logic             scan_in1,
  output logic             scan_in2,
  output logic             scan_in3,
  output logic             scan_in4,
  output logic             scan_enable,
  output logic             test_mode,
  input  logic             scan_out0,
  input  logic             scan_out1,
  input  logic             scan_out2,
  input  logic             scan_out3,
  input  logic             scan_out4,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             underrun,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] pattern_idx
);

  localparam int BIT_W = $clog2(CHAIN_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 5; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             unload_q, unload_d;
  logic [4:0]       exp_q, exp_d;
  logic [4:0]       mask_q, mask_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [4:0]       scan_in_q, scan_in_d;
  logic             scan_en_q, scan_en_d;
  logic             test_mode_q, test_mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             underrun_q, underrun_d;
  logic             pat_ready_q, pat_ready_d;

  logic [4:0]       scan_out_s;
  logic [4:0]       diff_s;
  logic [CNT_W:0]   sum_s;

  assign scan_out_s = {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0};
  assign diff_s     = (scan_out_s ^ exp_q) & mask_q;
  assign sum_s      = {1'b0, mis_q} + (CNT_W+1)'(popcount5(diff_s));

  // Next-state, counters, compare stage and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    mis_d      = mis_q;
    bit_d      = bit_q;
    unload_d   = unload_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    cmp_vld_d  = 1'b0;
    scan_in_d  = 5'b00000;
    scan_en_d  = 1'b0;
    fail_d     = fail_q;
    underrun_d = underrun_q;

    // The word accepted last cycle is being shifted now; its unload bit is checked at this edge.
    if (cmp_vld_q) begin
      mis_d = sum_s[CNT_W] ? CNT_MAX : sum_s[CNT_W-1:0];
      if (diff_s != 5'b00000) begin
        fail_d = 1'b1;
      end else begin
        fail_d = fail_q;
      end
    end else begin
      mis_d = mis_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = num_patterns;
          idx_d      = {CNT_W{1'b0}};
          mis_d      = {CNT_W{1'b0}};
          bit_d      = {BIT_W{1'b0}};
          unload_d   = 1'b0;
          fail_d     = 1'b0;
          underrun_d = 1'b0;
          state_d    = (num_patterns != {CNT_W{1'b0}}) ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (pat_valid) begin
          scan_in_d = unload_q ? 5'b00000 : pat_data;
          scan_en_d = 1'b1;
          exp_d     = pat_exp;
          mask_d    = pat_mask;
          cmp_vld_d = unload_q || (idx_q != {CNT_W{1'b0}});
          if (bit_q == LAST_BIT) begin
            bit_d   = {BIT_W{1'b0}};
            state_d = CAPTURE;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = SHIFT;
          end
        end else begin
          underrun_d = 1'b1;
          fail_d     = 1'b1;
          state_d    = DONE;
        end
      end
      CAPTURE: begin
        // No word is taken here, so scan_enable is low for the following (capture) edge.
        if (unload_q) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + CNT_W'(1);
          unload_d = (idx_q == (num_q - CNT_W'(1)));
          state_d  = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pat_ready_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT) || (state_d == CAPTURE);
    test_mode_d = busy_d;
    done_d      = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      num_q       <= {CNT_W{1'b0}};
      idx_q       <= {CNT_W{1'b0}};
      mis_q       <= {CNT_W{1'b0}};
      bit_q       <= {BIT_W{1'b0}};
      unload_q    <= 1'b0;
      exp_q       <= 5'b00000;
      mask_q      <= 5'b00000;
      cmp_vld_q   <= 1'b0;
      scan_in_q   <= 5'b00000;
      scan_en_q   <= 1'b0;
      test_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      underrun_q  <= 1'b0;
      pat_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      mis_q       <= mis_d;
      bit_q       <= bit_d;
      unload_q    <= unload_d;
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      cmp_vld_q   <= cmp_vld_d;
      scan_in_q   <= scan_in_d;
      scan_en_q   <= scan_en_d;
      test_mode_q <= test_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      underrun_q  <= underrun_d;
      pat_ready_q <= pat_ready_d;
    end
  end

  assign pat_ready    = pat_ready_q;
  assign scan_in0     = scan_in_q[0];
  assign scan_in1     = scan_in_q[1];
  assign scan_in2     = scan_in_q[2];
  assign scan_in3     = scan_in_q[3];
  assign scan_in4     = scan_in_q[4];
  assign scan_enable  = scan_en_q;
  assign test_mode    = test_mode_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign underrun     = underrun_q;
  assign mismatch_cnt = mis_q;
  assign pattern_idx  = idx_q;

endmodule

// File: doc/scan_pattern_engine.md
Name: scan_pattern_engine

Overview:
- Tester-side counterpart of the five-chain scan interface on our ADPCM arithmetic blocks (UPA2 and siblings).
- Consumes a stream of per-cycle stimulus/expected words.
- Drives scan_in0..4, scan_enable and test_mode into the DUT.
- Compares scan_out0..4 against expected data and reports mismatch counts, pass/fail and completion.
- Sits in the on-chip/bench test harness between a pattern source (ROM or FIFO) and the scanned core.

Parameters:
- CHAIN_LEN, 16, shift cycles per pattern (length of longest chain); ≥2.
- CNT_W, 16, width of the pattern-count, index and mismatch-counter fields.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a test session; sampled in IDLE only.
- num_patterns  in  CNT_W  patterns in the session; latched on start.
- pat_valid  in  1  stream word valid.
- pat_ready  out  1  engine accepts word this cycle.
- pat_data  in  5  stimulus bit per chain (bit n → scan_in n).
- pat_exp  in  5  expected unload bit per chain.
- pat_mask  in  5  1 = compare this chain's bit, 0 = don't care.
- scan_in0..scan_in4  out  1 each  serial stimulus to DUT chains.
- scan_enable  out  1  shift (1) / capture (0).
- test_mode  out  1  high for the whole session.
- scan_out0..scan_out4  in  1 each  serial response from DUT chains.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- fail  out  1  sticky: any mismatch or underrun.
- underrun  out  1  sticky: stream starved mid-shift.
- mismatch_cnt  out  CNT_W  saturating count of mismatching compared bits.
- pattern_idx  out  CNT_W  index of the pattern currently loading.

Behaviour:
- Reset: all outputs 0, FSM → IDLE, counters cleared. Applies mid-session with no drain; the next cycle is IDLE.
- All outputs are registered.
- FSM states: IDLE, SHIFT, CAPTURE, DONE.
- IDLE:
  - start=1 with num_patterns≠0: latch count; clear fail, underrun, mismatch_cnt, pattern_idx and bit counter; → SHIFT. busy=1 and test_mode=1 from the next cycle.
  - start=1 with num_patterns=0: → DONE directly; fail stays 0.
- SHIFT:
  - pat_ready=1.
  - Each accepted word (pat_valid&pat_ready) registers pat_data onto scan_in0..4 with scan_enable=1 for the following cycle. The DUT shifts that bit at the next edge.
  - pat_exp/pat_mask of the same word are pipelined one cycle. At that shifting edge, compare against scan_out0..4: mismatch_cnt += popcount((scan_out ^ exp) & mask), saturating at all-ones. Any nonzero result sets fail.
  - Pattern 0 load: compare is suppressed (chain contents unknown).
  - Final unload pass (after the last capture): pat_data is ignored and scan_in is driven 0; compares are active.
  - After CHAIN_LEN accepted words → CAPTURE, or → DONE if this was the unload pass.
  - pat_valid=0 while in SHIFT: set underrun and fail, scan_enable=0, → DONE (abort). The engine never stalls a partial shift.
- CAPTURE:
  - Exactly one cycle with scan_enable=0, pat_ready=0, test_mode=1.
  - Then increment pattern_idx.
  - If pattern_idx was num_patterns-1, next SHIFT is the unload pass; otherwise the next SHIFT loads the next pattern.
- DONE: done=1 for one cycle, busy=0, test_mode=0, scan_enable=0, → IDLE. fail, underrun and mismatch_cnt hold until the next start or reset.
- Stream word count per session: (num_patterns+1)·CHAIN_LEN.
- Latency: start → first pat_ready is 1 cycle. Last accepted unload word → done pulse is 2 cycles.
- start while busy is ignored.
- Simultaneous reset and start: reset wins.

Test Plan:
- CHAIN_LEN=4, num_patterns=2, loopback DUT (4-bit shift chains, capture = hold), exp = prior stimulus, mask=5'h1F → 12 words accepted, two scan_enable=0 single-cycle gaps, done pulse, fail=0, mismatch_cnt=0, pattern_idx=2.
- Same setup, exp bit2 inverted on one unload word → mismatch_cnt=1, fail=1. Repeat with pat_mask[2]=0 → mismatch_cnt=0, fail=0.
- Drop pat_valid for one cycle at word 6 → underrun=1, fail=1, done pulse within 2 cycles, scan_enable=0, test_mode=0.
- start with num_patterns=0 → done pulse next cycle, busy never high, pat_ready never high, fail=0.
- Assert reset on word 5 of a session → all outputs 0 next cycle. A following start with num_patterns=1 runs cleanly with mismatch_cnt=0.
- Force all five chains to mismatch for every compared cycle with CNT_W=4 → mismatch_cnt saturates at 15.
